// File: rtl/fb_read_arbiter.sv
// Shares the frame buffer's single registered read port between display scan-out (absolute priority)
// and the image-processing engine (req/ready), with out-of-range rejection and starvation tracking.
module fb_read_arbiter #(
    parameter int IMG_WIDTH    = 160,
    parameter int IMG_HEIGHT   = 120,
    parameter int ADDR_WIDTH   = $clog2(IMG_WIDTH*IMG_HEIGHT),
    parameter int STARVE_LIMIT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_disp_req,
    input  logic [ADDR_WIDTH-1:0] i_disp_addr,
    output logic                  o_disp_rvalid,
    output logic [15:0]           o_disp_rdata,
    input  logic                  i_proc_req,
    input  logic [ADDR_WIDTH-1:0] i_proc_addr,
    output logic                  o_proc_ready,
    output logic                  o_proc_rvalid,
    output logic [15:0]           o_proc_rdata,
    output logic                  o_proc_rerr,
    output logic                  o_proc_starved,
    output logic                  o_fb_oe,
    output logic [ADDR_WIDTH-1:0] o_fb_raddr,
    input  logic [15:0]           i_fb_rdata
);

    localparam int DEPTH = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]      CNT_PRE   = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_PROC = 2'd2
    } owner_t;

    owner_t           r_owner;
    owner_t           w_owner_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic [15:0]      r_disp_hold;
    logic [15:0]      r_proc_hold;
    logic             w_disp_in;
    logic             w_proc_in;
    logic             w_blocked;
    logic [15:0]      w_resp_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_owner     <= OWN_NONE;
            r_err       <= 1'b0;
            r_wait_cnt  <= '0;
            r_disp_hold <= '0;
            r_proc_hold <= '0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_err      <= w_err_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (o_disp_rvalid) r_disp_hold <= w_resp_data;
            if (o_proc_rvalid) r_proc_hold <= w_resp_data;
        end
    end

    always_comb begin
        w_disp_in      = (i_disp_addr <= LAST_ADDR);
        w_proc_in      = (i_proc_addr <= LAST_ADDR);
        o_proc_ready   = 1'b0;
        o_fb_oe        = 1'b0;
        o_fb_raddr     = '0;
        w_owner_nxt    = OWN_NONE;
        w_err_nxt      = 1'b0;
        if (i_disp_req) begin
            o_fb_oe     = w_disp_in;
            o_fb_raddr  = i_disp_addr;
            w_owner_nxt = OWN_DISP;
            w_err_nxt   = !w_disp_in;
        end else if (i_proc_req) begin
            o_proc_ready = 1'b1;
            o_fb_oe      = w_proc_in;
            o_fb_raddr   = i_proc_addr;
            w_owner_nxt  = OWN_PROC;
            w_err_nxt    = !w_proc_in;
        end
    end

    // Blocked means proc is asking while display holds the port; anything else restarts the count.
    always_comb begin
        w_blocked      = i_proc_req && i_disp_req;
        w_wait_cnt_nxt = '0;
        if (w_blocked) begin
            w_wait_cnt_nxt = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);
        end
        o_proc_starved = w_blocked && (r_wait_cnt == CNT_PRE);
    end

    always_comb begin
        w_resp_data   = r_err ? 16'h0000 : i_fb_rdata;
        o_disp_rvalid = (r_owner == OWN_DISP);
        o_proc_rvalid = (r_owner == OWN_PROC);
        o_disp_rdata  = o_disp_rvalid ? w_resp_data : r_disp_hold;
        o_proc_rdata  = o_proc_rvalid ? w_resp_data : r_proc_hold;
        o_proc_rerr   = o_proc_rvalid && r_err;
    end

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Randomized scoreboard bench for fb_read_arbiter with a behavioural frame buffer and reference model.
module tb_fb_read_arbiter;

    localparam int W     = 160;
    localparam int H     = 120;
    localparam int DEPTH = W * H;
    localparam int AW    = $clog2(DEPTH);
    localparam int LIM   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_rvalid;
    logic [15:0]   disp_rdata;
    logic          proc_req = 1'b0;
    logic [AW-1:0] proc_addr = '0;
    logic          proc_ready;
    logic          proc_rvalid;
    logic [15:0]   proc_rdata;
    logic          proc_rerr;
    logic          proc_starved;
    logic          fb_oe;
    logic [AW-1:0] fb_raddr;
    logic [15:0]   fb_rdata = '0;

    logic [15:0]   mem [DEPTH];
    logic [16:0]   dq[$];
    logic [16:0]   pq[$];
    int            total = 0;
    int            bad = 0;

    fb_read_arbiter #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_disp_req(disp_req), .i_disp_addr(disp_addr),
        .o_disp_rvalid(disp_rvalid), .o_disp_rdata(disp_rdata),
        .i_proc_req(proc_req), .i_proc_addr(proc_addr),
        .o_proc_ready(proc_ready), .o_proc_rvalid(proc_rvalid),
        .o_proc_rdata(proc_rdata), .o_proc_rerr(proc_rerr),
        .o_proc_starved(proc_starved),
        .o_fb_oe(fb_oe), .o_fb_raddr(fb_raddr), .i_fb_rdata(fb_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fb_oe) fb_rdata <= mem[fb_raddr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] expect_rd(input logic [AW-1:0] a);
        if (int'(a) < DEPTH) return {1'b0, mem[a]};
        return 17'h10000;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic drive(input logic dr, input logic [AW-1:0] da, input logic pr, input logic [AW-1:0] pa);
        disp_req  = dr;
        disp_addr = da;
        proc_req  = pr;
        proc_addr = pa;
        if (dr) dq.push_back(expect_rd(da));
        else if (pr) pq.push_back(expect_rd(pa));
        @(posedge clk);
        #1;
    endtask

    // Monitor: rule-level expectations for the combinational side, scoreboard pops for responses.
    int            run = 0;
    logic [15:0]   last_d = '0;
    logic [15:0]   last_p = '0;
    logic          m_blk;
    logic          m_oe;
    logic [AW-1:0] m_addr;
    logic [16:0]   m_e;

    always @(negedge clk) begin
        chk("proc_ready", proc_ready, proc_req && !disp_req);
        m_oe   = 1'b0;
        m_addr = '0;
        if (disp_req) begin
            m_oe = int'(disp_addr) < DEPTH; m_addr = disp_addr;
        end else if (proc_req) begin
            m_oe = int'(proc_addr) < DEPTH; m_addr = proc_addr;
        end
        chk("fb_oe", fb_oe, m_oe);
        chk("fb_raddr", fb_raddr, m_addr);
        chk("rvalid_excl", disp_rvalid && proc_rvalid, 1'b0);
        if (reset) begin
            run = 0; last_d = '0; last_p = '0;
            chk("rst_disp_rvalid", disp_rvalid, 1'b0);
            chk("rst_proc_rvalid", proc_rvalid, 1'b0);
            chk("rst_disp_rdata", disp_rdata, 16'h0);
            chk("rst_proc_rdata", proc_rdata, 16'h0);
            chk("rst_starved", proc_starved, 1'b0);
        end else begin
            m_blk = proc_req && disp_req;
            run   = m_blk ? run + 1 : 0;
            chk("proc_starved", proc_starved, m_blk && (run == LIM));
            if (disp_rvalid) begin
                if (dq.size() == 0) chk("disp_unexpected_q", dq.size(), 1);
                else begin
                    m_e = dq.pop_front();
                    chk("disp_rdata", disp_rdata, m_e[15:0]);
                    last_d = m_e[15:0];
                end
            end else chk("disp_hold", disp_rdata, last_d);
            if (proc_rvalid) begin
                if (pq.size() == 0) chk("proc_unexpected_q", pq.size(), 1);
                else begin
                    m_e = pq.pop_front();
                    chk("proc_rdata", proc_rdata, m_e[15:0]);
                    chk("proc_rerr", proc_rerr, m_e[16]);
                    last_p = m_e[15:0];
                end
            end else chk("proc_hold", proc_rdata, last_p);
        end
    end

    logic          pp;
    logic          dr;
    logic [AW-1:0] pa_h;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + 16'(i);
        mem[DEPTH-1] = 16'hBEEF;

        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // display only, addresses 0..3
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(i), 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0);

        // proc only, last valid address
        drive(1'b0, '0, 1'b1, AW'(DEPTH - 1));
        drive(1'b0, '0, 1'b0, '0);

        // contention then release
        for (int i = 0; i < 5; i++) drive(1'b1, rand_addr(), 1'b1, AW'(1234));
        drive(1'b0, '0, 1'b1, AW'(1234));
        drive(1'b0, '0, 1'b0, '0);

        // out of range on both ports
        drive(1'b0, '0, 1'b1, AW'(DEPTH));
        drive(1'b1, AW'(DEPTH), 1'b0, '0);
        drive(1'b0, '0, 1'b1, '1);
        drive(1'b1, '1, 1'b0, '0);
        drive(1'b0, '0, 1'b0, '0);

        // starvation, twice to show the counter clears after accept
        for (int i = 0; i < 10; i++) drive(1'b1, rand_addr(), 1'b1, AW'(77));
        drive(1'b0, '0, 1'b1, AW'(77));
        for (int i = 0; i < 5; i++) drive(1'b1, rand_addr(), 1'b1, AW'(78));
        drive(1'b0, '0, 1'b1, AW'(78));
        drive(1'b0, '0, 1'b0, '0);

        // reset the cycle after a proc accept: the in-flight response is dropped
        drive(1'b0, '0, 1'b1, AW'(100));
        reset     = 1'b1;
        disp_req  = 1'b0;
        proc_req  = 1'b1;
        proc_addr = AW'(200);
        dq.delete();
        pq.delete();
        #1;
        chk("rst_mid_proc_rvalid", proc_rvalid, 1'b0);
        chk("rst_mid_proc_rdata", proc_rdata, 16'h0);
        chk("rst_mid_fb_oe", fb_oe, 1'b1);
        chk("rst_mid_ready", proc_ready, 1'b1);
        @(posedge clk); #1;
        proc_req = 1'b0;
        reset    = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, 1'b1, AW'(300));
        drive(1'b0, '0, 1'b0, '0);

        // randomized traffic; proc holds its request and address until accepted
        pp   = 1'b0;
        pa_h = '0;
        for (int i = 0; i < 400; i++) begin
            dr = ($urandom_range(0, 2) != 0);
            if (!pp) begin
                pp   = ($urandom_range(0, 1) == 1);
                pa_h = rand_addr();
            end
            drive(dr, rand_addr(), pp, pa_h);
            if (pp && !dr) pp = 1'b0;
        end

        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, '0);
        chk("disp_q_drained", dq.size(), 0);
        chk("proc_q_drained", pq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
